chi3_round_ctrl: RTL and testbench

//  Round controller sequencing one external 2-share masked Chi3 (Toffoli) gadget over ROUNDS rounds.

---
 rtl/chi3_ctrl_pkg.sv | 21 ++
 rtl/chi3_ctrl_linear.sv | 17 +
 rtl/chi3_round_ctrl.sv | 172 +++++++++++++++++
 tb/tb_chi3_round_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chi3_ctrl_pkg.sv
// Shared types and defaults for the masked Chi3 round controller.
package chi3_ctrl_pkg;

    typedef logic [1:0] share_t;

    typedef struct packed {
        share_t a;
        share_t b;
        share_t c;
    } lane3_t;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StCheck,
        StDone
    } state_t;

    localparam logic [3:0] DefaultRc = 4'b1011;

endpackage

// File: rtl/chi3_ctrl_linear.sv
// Linear layer between rounds: lane rotation plus round-constant injection on share 0.
module chi3_ctrl_linear
    import chi3_ctrl_pkg::*;
(
    input  lane3_t x_i,
    input  logic   rc_i,
    output lane3_t y_o
);

    always_comb begin
        y_o.a = x_i.b;
        y_o.b = x_i.c;
        // Constant goes on share 0 only so the lane value flips without touching share 1.
        y_o.c = x_i.a ^ {1'b0, rc_i};
    end

endmodule

// File: rtl/chi3_round_ctrl.sv
// Round controller driving an external 2-share Chi3 gadget for ROUNDS rounds.
// CHI3_CTRL_FAULT_DETECT_EN adds a second evaluation per round and a sticky fault flag.
module chi3_round_ctrl
    import chi3_ctrl_pkg::*;
#(
    parameter int unsigned       ROUNDS     = 4,
    parameter int unsigned       GADGET_LAT = 2,
    parameter logic [ROUNDS-1:0] RC         = ROUNDS'(DefaultRc)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_a,
    input  logic [1:0] in_b,
    input  logic [1:0] in_c,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_a,
    output logic [1:0] out_b,
    output logic [1:0] out_c,
    output logic       busy,
    output logic       fault,
    output logic [1:0] gad_a_i,
    output logic [1:0] gad_b_i,
    output logic [1:0] gad_c_i,
    input  logic [1:0] gad_a_o,
    input  logic [1:0] gad_b_o,
    input  logic [1:0] gad_c_o
);

    localparam int unsigned   RW        = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int unsigned   WW        = (GADGET_LAT > 1) ? $clog2(GADGET_LAT) : 1;
    localparam logic [RW-1:0] LastRound = RW'(ROUNDS - 1);
    localparam logic [WW-1:0] LastWait  = WW'(GADGET_LAT - 1);

    state_t        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    lane3_t        st_q, st_d;
    lane3_t        gad_res, lin_out;
    logic          rc_bit, sample, advance;
`ifdef CHI3_CTRL_FAULT_DETECT_EN
    lane3_t        shadow_q, shadow_d;
    logic          fault_q, fault_d;
`endif

    assign gad_res = {gad_a_o, gad_b_o, gad_c_o};
    assign gad_a_i = st_q.a;
    assign gad_b_i = st_q.b;
    assign gad_c_i = st_q.c;
    assign sample  = (wcnt_q == LastWait);

    always_comb begin
        rc_bit = 1'b0;
        for (int unsigned r = 0; r < ROUNDS; r++) begin
            if (round_q == RW'(r)) rc_bit = RC[r];
        end
    end

    chi3_ctrl_linear u_linear (
        .x_i  (gad_res),
        .rc_i (rc_bit),
        .y_o  (lin_out)
    );

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        wcnt_d   = wcnt_q;
        st_d     = st_q;
        advance  = 1'b0;
`ifdef CHI3_CTRL_FAULT_DETECT_EN
        shadow_d = shadow_q;
        fault_d  = fault_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    st_d    = {in_a, in_b, in_c};
                    round_d = '0;
                    wcnt_d  = '0;
                    state_d = StEval;
`ifdef CHI3_CTRL_FAULT_DETECT_EN
                    fault_d = 1'b0;
`endif
                end
            end
            StEval: begin
                if (sample) begin
`ifdef CHI3_CTRL_FAULT_DETECT_EN
                    shadow_d = gad_res;
                    wcnt_d   = '0;
                    state_d  = StCheck;
`else
                    advance  = 1'b1;
`endif
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
`ifdef CHI3_CTRL_FAULT_DETECT_EN
            StCheck: begin
                if (sample) begin
                    // Bitwise compare keeps share 0 against share 0 and share 1 against share 1.
                    if (gad_res == shadow_q) begin
                        advance = 1'b1;
                    end else begin
                        fault_d = 1'b1;
                        st_d    = '0;
                        state_d = StDone;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
`endif
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (advance) begin
            st_d = lin_out;
            if (round_q == LastRound) begin
                state_d = StDone;
            end else begin
                round_d = round_q + 1'b1;
                wcnt_d  = '0;
                state_d = StEval;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            round_q  <= '0;
            wcnt_q   <= '0;
            st_q     <= '0;
`ifdef CHI3_CTRL_FAULT_DETECT_EN
            shadow_q <= '0;
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            wcnt_q   <= wcnt_d;
            st_q     <= st_d;
`ifdef CHI3_CTRL_FAULT_DETECT_EN
            shadow_q <= shadow_d;
            fault_q  <= fault_d;
`endif
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        out_valid = (state_q == StDone);
        out_a     = out_valid ? st_q.a : '0;
        out_b     = out_valid ? st_q.b : '0;
        out_c     = out_valid ? st_q.c : '0;
`ifdef CHI3_CTRL_FAULT_DETECT_EN
        fault     = fault_q;
`else
        fault     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_chi3_round_ctrl.sv
// Directed bench for chi3_round_ctrl with a behavioural 2-share Chi3 gadget (one output register).
// Fault-detect paths are exercised when CHI3_CTRL_FAULT_DETECT_EN is defined.
module tb_chi3_round_ctrl;

`ifdef CHI3_CTRL_FAULT_DETECT_EN
    localparam int Mul = 2;
`else
    localparam int Mul = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_valid, in_valid1, out_ready, flip;
    logic [1:0] in_a, in_b, in_c;

    logic       in_ready, out_valid, busy, fault;
    logic [1:0] out_a, out_b, out_c, gai, gbi, gci, gao, gbo, gco;
    logic [5:0] g_q;

    logic       in_ready1, out_valid1, busy1, fault1;
    logic [1:0] out_a1, out_b1, out_c1, gai1, gbi1, gci1, gao1, gbo1, gco1;
    logic [5:0] g1_q;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    // Output share 0 reuses input share 0 of the same lane; share 1 carries the Chi3 value.
    function automatic logic [5:0] chi_gad(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] c);
        logic va, vb, vc, ya, yb, yc;
        va = a[1] ^ a[0];
        vb = b[1] ^ b[0];
        vc = c[1] ^ c[0];
        ya = va ^ (~vb & vc);
        yb = vb ^ (~vc & va);
        yc = vc ^ (~va & vb);
        return {a[0] ^ ya, a[0], b[0] ^ yb, b[0], c[0] ^ yc, c[0]};
    endfunction

    always_ff @(posedge clk) g_q  <= chi_gad(gai, gbi, gci);
    always_ff @(posedge clk) g1_q <= chi_gad(gai1, gbi1, gci1);

    assign gao  = g_q[5:4] ^ {1'b0, flip};
    assign gbo  = g_q[3:2];
    assign gco  = g_q[1:0];
    assign gao1 = g1_q[5:4];
    assign gbo1 = g1_q[3:2];
    assign gco1 = g1_q[1:0];

    chi3_round_ctrl #(
        .ROUNDS     (4),
        .GADGET_LAT (2),
        .RC         (4'b1011)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .busy      (busy),
        .fault     (fault),
        .gad_a_i   (gai),
        .gad_b_i   (gbi),
        .gad_c_i   (gci),
        .gad_a_o   (gao),
        .gad_b_o   (gbo),
        .gad_c_o   (gco)
    );

    chi3_round_ctrl #(
        .ROUNDS     (1),
        .GADGET_LAT (2),
        .RC         (1'b0)
    ) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_a     (out_a1),
        .out_b     (out_b1),
        .out_c     (out_c1),
        .busy      (busy1),
        .fault     (fault1),
        .gad_a_i   (gai1),
        .gad_b_i   (gbi1),
        .gad_c_i   (gci1),
        .gad_a_o   (gao1),
        .gad_b_o   (gbo1),
        .gad_c_o   (gco1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        in_a     = a;
        in_b     = b;
        in_c     = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!out_valid && cnt < 100);
    endtask

    function automatic logic [2:0] unshare(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] c);
        return {a[1] ^ a[0], b[1] ^ b[0], c[1] ^ c[0]};
    endfunction

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0; flip = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;
        tick();
        tick();
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_out", {out_a, out_b, out_c}, 0);
        reset = 1'b1;
        tick();

        // ROUNDS=1, RC=0: (0,0,1) -> (0,1,1)
        in_a = 2'b00; in_b = 2'b11; in_c = 2'b10; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        check_eq("t1_busy", busy1, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid1 && n < 100);
        check_eq("t1_latency", n, 2 * Mul);
        check_eq("t1_shares", {out_a1, out_b1, out_c1}, 6'b11_10_10);
        check_eq("t1_value", unshare(out_a1, out_b1, out_c1), 3'b011);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("t1_idle_valid", out_valid1, 0);
        check_eq("t1_idle_ready", in_ready1, 1);

        // ROUNDS=4, RC=1011: (1,0,1) -> (1,1,1)
        accept(2'b10, 2'b11, 2'b01);
        check_eq("t2_busy", busy, 1);
        check_eq("t2_out_zero_eval", {out_a, out_b, out_c}, 0);
        check_eq("t2_valid_eval", out_valid, 0);
        wait_out(n);
        check_eq("t2_latency", n, 8 * Mul);
        check_eq("t2_shares", {out_a, out_b, out_c}, 6'b10_01_10);
        check_eq("t2_value", unshare(out_a, out_b, out_c), 3'b111);
        check_eq("t2_fault", fault, 0);

        // Stall in DONE; in_valid pulses must be ignored
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_a = 2'b01; in_b = 2'b01; in_c = 2'b01;
            tick();
            check_eq("t3_hold_valid", out_valid, 1);
            check_eq("t3_hold_out", {out_a, out_b, out_c}, 6'b10_01_10);
            check_eq("t3_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("t3_release_valid", out_valid, 0);
        check_eq("t3_release_busy", busy, 0);
        check_eq("t3_release_out", {out_a, out_b, out_c}, 0);

        // Reset during round 2, then a clean operation
        accept(2'b10, 2'b11, 2'b01);
        repeat (4) tick();
        check_eq("t4_busy_before", busy, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("t4_rst_valid", out_valid, 0);
        check_eq("t4_rst_busy", busy, 0);
        check_eq("t4_rst_ready", in_ready, 1);
        accept(2'b10, 2'b11, 2'b01);
        wait_out(n);
        check_eq("t4_latency", n, 8 * Mul);
        check_eq("t4_shares", {out_a, out_b, out_c}, 6'b10_01_10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

`ifdef CHI3_CTRL_FAULT_DETECT_EN
        // Corrupt the second evaluation of round 1
        accept(2'b10, 2'b11, 2'b01);
        repeat (6) tick();
        flip = 1'b1;
        repeat (2) tick();
        flip = 1'b0;
        check_eq("t5_valid", out_valid, 1);
        check_eq("t5_fault", fault, 1);
        check_eq("t5_out_zero", {out_a, out_b, out_c}, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("t5_fault_sticky", fault, 1);
        accept(2'b10, 2'b11, 2'b01);
        check_eq("t5_fault_clear", fault, 0);
        wait_out(n);
        check_eq("t5_recover", {out_a, out_b, out_c}, 6'b10_01_10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        // Back-to-back with in_valid and out_ready held high
        in_a = 2'b10; in_b = 2'b11; in_c = 2'b01;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        check_eq("t6_first_accept", busy, 1);
        in_a = 2'b11; in_b = 2'b00; in_c = 2'b01;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check_eq("t6_lat1", n, 8 * Mul);
        check_eq("t6_res1", {out_a, out_b, out_c}, 6'b10_01_10);
        tick();
        check_eq("t6_no_same_edge_accept", busy, 0);
        tick();
        check_eq("t6_second_accept", busy, 1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check_eq("t6_lat2", n, 8 * Mul);
        check_eq("t6_res2", {out_a, out_b, out_c}, 6'b01_01_11);
        check_eq("t6_val2", unshare(out_a, out_b, out_c), 3'b110);
        tick();
        out_ready = 1'b0;
        check_eq("t6_final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
